// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : micro_sequencer
// Description : Micro-step sequencer for a microcoded CPU. It steps the
//               control-ROM address through the micro-steps of each
//               instruction, detects end-of-instruction, evaluates the branch
//               condition and runs an IDLE/RUN/STEP/HALTED operator FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter int HALT_BIT  = 0,
  parameter int LAST_STEP = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  instruction,
  input  logic [31:0] control_lines,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_n,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        stop_req,
  output logic [1:0]  micro_counter,
  output logic        flags_valid,
  output logic        seq_active,
  output logic        halted,
  output logic        instr_done,
  output logic [15:0] instr_count
);

  // The micro-step counter stays 2 bits wide whatever LAST_STEP is set to.
  localparam logic [1:0] c_last_step = LAST_STEP[1:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    STEP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  micro_counter_q, micro_counter_d;
  logic        instr_done_q, instr_done_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        stop_pending_q, stop_pending_d;

  logic w_active;
  logic w_halt_bit;
  logic w_eoi;
  logic w_stop_eff;

  // Active-cycle qualification and end-of-instruction detection.
  always_comb begin
    w_active   = (state_q == RUN) || (state_q == STEP);
    w_halt_bit = control_lines[HALT_BIT];
    w_eoi      = w_active &&
                 ((micro_counter_q == c_last_step) ||
                  ((micro_counter_q >= 2'd2) && (control_lines == 32'd0)) ||
                  w_halt_bit);
    // A stop arriving in the EOI cycle itself still counts at that EOI.
    w_stop_eff = stop_pending_q || stop_req;
  end

  // Branch condition from the instruction's condition field.
  always_comb begin
    flags_valid = 1'b0;
    case (instruction[7:5])
      3'd0:    flags_valid = 1'b1;
      3'd1:    flags_valid = flag_z;
      3'd2:    flags_valid = !flag_z;
      3'd3:    flags_valid = flag_c;
      3'd4:    flags_valid = !flag_c;
      3'd5:    flags_valid = flag_n;
      3'd6:    flags_valid = !flag_n;
      default: flags_valid = 1'b0;
    endcase
  end

  // Next-state, micro-step counter, retire counter and stop-pending logic.
  always_comb begin
    state_d         = state_q;
    micro_counter_d = 2'd0;
    instr_done_d    = w_eoi;
    instr_count_d   = instr_count_q;
    stop_pending_d  = stop_pending_q;

    if (w_active) begin
      micro_counter_d = w_eoi ? 2'd0 : micro_counter_q + 2'd1;
    end

    if (w_eoi) begin
      instr_count_d = instr_count_q + 16'd1;
    end

    case (state_q)
      IDLE, HALTED: begin
        // Requests are only honoured while stopped; run beats step.
        if (run_req) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d = STEP;
        end
      end
      RUN: begin
        if (w_eoi && (w_halt_bit || w_stop_eff)) begin
          state_d = HALTED;
        end
      end
      STEP: begin
        if (w_eoi) begin
          state_d = HALTED;
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_active && stop_req) begin
      stop_pending_d = 1'b1;
    end
    // Entering HALTED consumes any pending stop.
    if (state_d == HALTED && state_q != HALTED) begin
      stop_pending_d = 1'b0;
    end
  end

  // State registers; reset abandons any in-flight instruction silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      micro_counter_q <= 2'd0;
      instr_done_q    <= 1'b0;
      instr_count_q   <= 16'd0;
      stop_pending_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      micro_counter_q <= micro_counter_d;
      instr_done_q    <= instr_done_d;
      instr_count_q   <= instr_count_d;
      stop_pending_q  <= stop_pending_d;
    end
  end

  // Output mapping.
  always_comb begin
    micro_counter = micro_counter_q;
    seq_active    = (state_q == RUN) || (state_q == STEP);
    halted        = (state_q == HALTED);
    instr_done    = instr_done_q;
    instr_count   = instr_count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_sequencer
// Description : Directed self-checking bench for micro_sequencer. Expected
//               retire counts are queued when an instruction is launched and
//               checked when instr_done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  instruction;
  logic [31:0] control_lines;
  logic        flag_z, flag_c, flag_n;
  logic        run_req, step_req, stop_req;
  logic [1:0]  micro_counter;
  logic        flags_valid;
  logic        seq_active;
  logic        halted;
  logic        instr_done;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;
  logic [15:0] sb[$];
  logic [31:0] rom[4];

  micro_sequencer #(.HALT_BIT(0), .LAST_STEP(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instruction   (instruction),
    .control_lines (control_lines),
    .flag_z        (flag_z),
    .flag_c        (flag_c),
    .flag_n        (flag_n),
    .run_req       (run_req),
    .step_req      (step_req),
    .stop_req      (stop_req),
    .micro_counter (micro_counter),
    .flags_valid   (flags_valid),
    .seq_active    (seq_active),
    .halted        (halted),
    .instr_done    (instr_done),
    .instr_count   (instr_count)
  );

  // Control ROM model: word selected by the current micro-step.
  assign control_lines = rom[micro_counter];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then service the retire scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (instr_done === 1'b1) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else                chk("retire_count", {16'd0, instr_count}, {16'd0, sb.pop_front()});
    end
  endtask

  function automatic logic fv_model(input logic [2:0] c, input logic z, input logic cy, input logic n);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      3'd5: return n;
      3'd6: return !n;
      default: return 1'b0;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; instruction = 8'h00;
    flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0;
    run_req = 1'b0; step_req = 1'b0; stop_req = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 32'h10;
    #2;
    // Reset state
    chk("rst_mc", micro_counter, 0);
    chk("rst_active", seq_active, 0);
    chk("rst_halted", halted, 0);
    chk("rst_done", instr_done, 0);
    chk("rst_count", instr_count, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_after_rst", seq_active, 0);

    // Full four-step instructions in RUN
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("run_latency_active", seq_active, 1);
    chk("run_latency_mc", micro_counter, 0);
    sb.push_back(16'd1); sb.push_back(16'd2);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("seq4_mc", micro_counter, i % 4);
      chk("seq4_done", instr_done, (i == 4) ? 1 : 0);
    end
    chk("count_after_1", instr_count, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("done_2nd", instr_done, 1);
    chk("count_after_2", instr_count, 2);

    // Early EOI: zero control word at step 2
    rom[2] = 32'h0;
    sb.push_back(16'd3);
    tick(); chk("early_mc1", micro_counter, 1);
    tick(); chk("early_mc2", micro_counter, 2);
    tick(); chk("early_mc0", micro_counter, 0);
    chk("early_done", instr_done, 1);
    rom[2] = 32'h10;

    // HALT bit at step 1
    rom[1] = 32'h1;
    sb.push_back(16'd4);
    tick(); chk("halt_mc1", micro_counter, 1);
    tick();
    chk("halt_halted", halted, 1);
    chk("halt_active", seq_active, 0);
    chk("halt_mc", micro_counter, 0);
    chk("halt_count", instr_count, 4);
    rom[1] = 32'h10;
    tick();
    chk("halt_done_once", instr_done, 0);
    chk("halt_hold_mc", micro_counter, 0);

    // Single step from HALTED
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    chk("step_active", seq_active, 1);
    chk("step_not_halted", halted, 0);
    sb.push_back(16'd5);
    for (int i = 0; i < 3; i++) tick();
    chk("step_mc3", micro_counter, 3);
    tick();
    chk("step_halted", halted, 1);
    chk("step_done", instr_done, 1);

    // run_req and step_req together: RUN wins, continues past EOI
    run_req = 1'b1; step_req = 1'b1;
    tick();
    run_req = 1'b0; step_req = 1'b0;
    chk("both_active", seq_active, 1);
    sb.push_back(16'd6);
    for (int i = 0; i < 4; i++) tick();
    chk("both_done", instr_done, 1);
    chk("both_still_run", seq_active, 1);

    // stop_req at step 1: instruction completes, then HALTED
    tick(); chk("stop_mc1", micro_counter, 1);
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    chk("stop_continues", seq_active, 1);
    sb.push_back(16'd7);
    tick();
    chk("stop_mc3", micro_counter, 3);
    tick();
    chk("stop_halted", halted, 1);
    chk("stop_count", instr_count, 7);

    // stop_req while HALTED has no effect
    stop_req = 1'b1;
    tick();
    stop_req = 1'b0;
    tick();
    chk("stop_in_halt", halted, 1);

    // Pending stop cleared: next RUN keeps running after first instruction
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    sb.push_back(16'd8);
    for (int i = 0; i < 4; i++) tick();
    chk("rerun_active", seq_active, 1);

    // stop_req in the EOI cycle takes effect at that EOI
    for (int i = 0; i < 3; i++) tick();
    chk("eoi_stop_mc3", micro_counter, 3);
    stop_req = 1'b1;
    sb.push_back(16'd9);
    tick();
    stop_req = 1'b0;
    chk("eoi_stop_halted", halted, 1);
    chk("eoi_stop_count", instr_count, 9);

    // Condition-field sweep
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        instruction = {c[2:0], 5'd0};
        flag_z = f[0]; flag_c = f[1]; flag_n = f[2];
        #1;
        chk("flags_valid", flags_valid, fv_model(c[2:0], f[0], f[1], f[2]));
      end
    end
    instruction = 8'h00;
    flag_z = 1'b0; flag_c = 1'b0; flag_n = 1'b0;

    // Reset mid-instruction abandons it
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    tick(); tick();
    chk("mid_mc2", micro_counter, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_active", seq_active, 0);
    chk("mid_rst_mc", micro_counter, 0);
    chk("mid_rst_count", instr_count, 0);
    chk("mid_rst_done", instr_done, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_idle", seq_active, 0);
    chk("post_rst_not_halted", halted, 0);
    chk("post_rst_count", instr_count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
